// File: rtl/serial_adder_ctrl_if.sv
// Purpose: groups the request/response signals of the bit-serial adder sequencer.
//   The master issues start/A/B/cin. The slave (serial_adder_ctrl) answers with
//   busy/done/sum/carryOut.
// Ports (members):
//   start    - request a new addition (master -> slave)
//   A, B     - WIDTH-bit operands (master -> slave)
//   cin      - initial carry-in (master -> slave)
//   busy     - sequencer is stepping through bits (slave -> master)
//   done     - one-cycle completion strobe (slave -> master)
//   sum      - WIDTH-bit registered result (slave -> master)
//   carryOut - registered final carry (slave -> master)
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryOut;

  modport master (
    output start, A, B, cin,
    input  busy, done, sum, carryOut
  );

  modport slave (
    input  start, A, B, cin,
    output busy, done, sum, carryOut
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Purpose: bit-serial WIDTH-bit adder sequencer. It captures A/B/cin on an
//   accepted start, then pushes one bit pair per clock, LSB first, through a
//   one-bit full-adder cell. The carry is held in a flip-flop between bits, and
//   the sum bits collect in an accumulator. After the last bit the result is
//   latched into sum/carryOut and done pulses for one cycle.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset, dominates everything
//   bus   - slave side of serial_adder_ctrl_if (start/A/B/cin in,
//           busy/done/sum/carryOut out)
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_adder_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One-bit full-adder cell: sum bit and carry (majority) as helpers
  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic             creg_q, creg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             z_s;
  logic             c_s;
  logic [WIDTH-1:0] acc_shift_s;

  assign z_s = fa_sum(sha_q[0], shb_q[0], creg_q);
  assign c_s = fa_carry(sha_q[0], shb_q[0], creg_q);

  // The new sum bit enters at the MSB, so after WIDTH shifts bit 0 lands at index 0.
  // A one-bit accumulator has no upper bits to keep, so it gets its own branch.
  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign acc_shift_s = z_s;
    end else begin : g_acc_wn
      assign acc_shift_s = {z_s, acc_q[WIDTH-1:1]};
    end
  endgenerate

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      creg_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      creg_q  <= creg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    creg_d  = creg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sha_d   = bus.A;
          shb_d   = bus.B;
          creg_d  = bus.cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        creg_d = c_s;
        acc_d  = acc_shift_s;
        sha_d  = sha_q >> 1;
        shb_d  = shb_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        // The last bit also publishes the result. sum/carryOut stay
        // untouched for the rest of the run.
        if (cnt_q == LAST_BIT) begin
          sum_d   = acc_shift_s;
          cout_d  = c_s;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.sum      = sum_q;
  assign bus.carryOut = cout_q;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder sequencer. It loads two operands and a carry-in, then feeds one bit pair per clock, LSB first, through a one-bit full-adder cell, with the carry held in a flip-flop between bits.
- It collects the resulting sum bits into a word and reports completion.
- It is the stage directly upstream and downstream of the one-bit full adder: it drives X/Y/carryIn and consumes Z/carryOut.
- Used on the Nexys4 DDR board for switch-driven serial addition demos.

Parameters:
- WIDTH, 8, operand and sum width in bits. Legal range is 1..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepted start edge.
- B  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  initial carry-in; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  high for exactly one cycle when the result is valid.
- sum  output  WIDTH  registered result; held until the next completion.
- carryOut  output  1  registered final carry; held with sum.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - state=IDLE.
  - busy=0, done=0, sum=0, carryOut=0.
  - Internal shift registers, carry flip-flop and bit counter are all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: shA<=A, shB<=B, cReg<=cin, bitCnt<=0, accumulator<=0, state<=RUN.
  - Otherwise remain in IDLE.
- RUN, each edge processes one bit:
  - Full-adder cell inputs: X=shA[0], Y=shB[0], carryIn=cReg.
  - Cell outputs: z = X^Y^cReg; c = majority(X, Y, cReg).
  - Updates: cReg<=c; accumulator shifts right with z entering at the MSB; shA and shB shift right by 1; bitCnt<=bitCnt+1.
  - The edge that processes bit index WIDTH-1 also loads sum<=final accumulator and carryOut<=c, and sets state<=DONE.
- DONE: done=1 for this one cycle; state<=IDLE on the next edge.
- busy and done are combinational decodes of the state register: busy=(state==RUN), done=(state==DONE). No glitches beyond state-register timing.
- Latency: start accepted at edge k.
  - busy=1 after edges k .. k+WIDTH-1.
  - sum, carryOut and done become valid after edge k+WIDTH.
  - done returns to 0 after edge k+WIDTH+1.
  - Total occupancy is WIDTH+2 cycles, including the IDLE sampling cycle.
- Arithmetic: {carryOut,sum} == A+B+cin, full WIDTH+1-bit result, no truncation beyond the carry.
- start while in RUN or DONE is ignored: no restart, no queueing, operands unchanged.
- start held high continuously starts a new operation every WIDTH+2 cycles, re-sampling A/B/cin at each IDLE edge.
- A, B and cin may change freely after the accepted edge without affecting the result in progress.
- sum and carryOut are not updated during RUN. They show the previous result, or 0 after reset, until the completing edge.
- Reset asserted mid-RUN or in DONE:
  - Abort; all outputs go to 0 on that edge; no done pulse.
  - The next start after reset deasserts is accepted normally.
- bitCnt width is $clog2(WIDTH)+1. WIDTH=1 must work: a single RUN cycle, then DONE.

Test Plan (WIDTH=8):
1. Reset for 2 cycles, release, A=0x00, B=0x00, cin=0, start pulse at edge k -> busy=1 for 8 cycles; after edge k+8: done=1 for one cycle, sum=0x00, carryOut=0.
2. A=0x3C, B=0x0F, cin=0 -> sum=0x4B, carryOut=0. Then A=0xFF, B=0x01, cin=0 -> sum=0x00, carryOut=1.
3. A=0xA5, B=0x5A, cin=1 -> sum=0x00, carryOut=1. sum stays 0x4B-free and unchanged during RUN until the completing edge.
4. Start A=0x12, B=0x34, cin=0; at edge k+3 drive start=1 with A=0xFF, B=0xFF -> ignored; result sum=0x46, carryOut=0, single done pulse at k+8.
5. Start A=0x80, B=0x80; assert reset at edge k+4 -> after that edge busy=0, done=0, sum=0x00, carryOut=0, no done pulse follows. Subsequent start with A=0x01, B=0x01 -> sum=0x02.
6. start held high, A=0x01, B=0x02, cin=1 -> done pulses every 10 cycles, each time with sum=0x04, carryOut=0.
